excp_ctrl: RTL and testbench

//  Exception/interrupt control unit: initiator side of the CP0 exception interface. Samples MEM-stage

---
 rtl/excp_ctrl_pkg.sv | 41 ++++
 rtl/excp_ctrl_if.sv | 35 +++
 rtl/excp_ctrl_prio.sv | 43 ++++
 rtl/excp_ctrl.sv | 117 +++++++++++
 tb/tb_excp_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/excp_ctrl_pkg.sv
// Shared types and constants for the exception control unit.
// Exception codes, CP0 bit positions and FSM encodings.
package excp_ctrl_pkg;

  localparam logic [31:0] ZERO        = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0004;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
  localparam logic [31:0] EXC_ERET    = 32'h0000_0200;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int IM_LO  = 8;
  localparam int IM_HI  = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH,
    S_REDIR
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_INT,
    K_SYS,
    K_ERET
  } kind_t;

  function automatic logic [31:0] kind_code(kind_t k);
    logic [31:0] c;
    c = ZERO;
    unique case (k)
      K_INT:   c = EXC_INT;
      K_SYS:   c = EXC_SYSCALL;
      K_ERET:  c = EXC_ERET;
      default: c = ZERO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/excp_ctrl_if.sv
// MEM-stage sources, CP0 exception port and fetch redirect.
// master = exception controller, slave = pipeline/CP0 side.
interface excp_ctrl_if;

  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        is_syscall;
  logic        is_eret;
  logic        stall;
  logic        intimer;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] excptype;
  logic [31:0] excp_pc;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic        busy;

  modport master (
    input  mem_valid, mem_pc, is_syscall, is_eret,
    input  stall, intimer, status, cause, epc,
    output excptype, excp_pc, flush,
    output new_pc, new_pc_valid, busy
  );

  modport slave (
    output mem_valid, mem_pc, is_syscall, is_eret,
    output stall, intimer, status, cause, epc,
    input  excptype, excp_pc, flush,
    input  new_pc, new_pc_valid, busy
  );

endinterface

// File: rtl/excp_ctrl_prio.sv
// Interrupt qualification and priority encode.
// Interrupt beats syscall beats eret.
module excp_prio
  import excp_ctrl_pkg::*;
(
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic        timer_pend,
  input  logic        mem_valid,
  input  logic        is_syscall,
  input  logic        is_eret,
  output logic        req,
  output kind_t       kind
);

  logic int_req;
  logic sys;
  logic ert;
  logic unused_bits;

  assign unused_bits = ^{status[31:16], status[7:2],
                         cause[31:16], cause[7:0]};

  assign int_req = status[ST_IE] & ~status[ST_EXL] &
                   ((|(cause[IM_HI:IM_LO] &
                       status[IM_HI:IM_LO])) |
                    timer_pend);
  assign sys = mem_valid & is_syscall;
  assign ert = mem_valid & is_eret;

  always_comb begin
    kind = K_NONE;
    unique case (1'b1)
      int_req:               kind = K_INT;
      (~int_req & sys):      kind = K_SYS;
      (~int_req & ~sys & ert): kind = K_ERET;
      default:               kind = K_NONE;
    endcase
  end

  assign req = (kind != K_NONE);

endmodule

// File: rtl/excp_ctrl.sv
// Exception/interrupt controller: accept, issue to CP0,
// flush the pipeline, then redirect fetch.
module excp_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  excp_ctrl_if.master bus
);
  import excp_ctrl_pkg::*;

  localparam logic [7:0] CNT_INIT =
    (FLUSH_CYCLES > 1) ? 8'(FLUSH_CYCLES - 2) : 8'd0;
  localparam bit HAS_FLUSH = (FLUSH_CYCLES > 1);

  state_t      state;
  state_t      state_nx;
  kind_t       kind_q;
  kind_t       kind_d;
  logic [31:0] pc_q;
  logic [7:0]  cnt;
  logic        timer_pend;
  logic        req;
  logic        accept;

  logic [31:0] excptype;
  logic [31:0] excp_pc;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic        busy;

  excp_prio u_prio (
    .status     (bus.status),
    .cause      (bus.cause),
    .timer_pend (timer_pend),
    .mem_valid  (bus.mem_valid),
    .is_syscall (bus.is_syscall),
    .is_eret    (bus.is_eret),
    .req        (req),
    .kind       (kind_d)
  );

  assign accept = (state == S_IDLE) & ~bus.stall & req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      kind_q     <= K_NONE;
      pc_q       <= ZERO;
      cnt        <= 8'd0;
      timer_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        kind_q <= kind_d;
        pc_q   <= bus.mem_pc;
      end
      // a new tick in the issue cycle must not be lost
      if (bus.intimer)
        timer_pend <= 1'b1;
      else if (state == S_ISSUE && kind_q == K_INT)
        timer_pend <= 1'b0;
      if (state == S_ISSUE)
        cnt <= CNT_INIT;
      else if (state == S_FLUSH)
        cnt <= cnt - 8'd1;
    end
  end

  always_comb begin
    state_nx     = state;
    excptype     = ZERO;
    excp_pc      = ZERO;
    flush        = 1'b0;
    new_pc       = ZERO;
    new_pc_valid = 1'b0;
    busy         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        excptype = kind_code(kind_q);
        excp_pc  = pc_q;
        flush    = 1'b1;
        busy     = 1'b1;
        state_nx = HAS_FLUSH ? S_FLUSH : S_REDIR;
      end
      S_FLUSH: begin
        flush = 1'b1;
        busy  = 1'b1;
        if (cnt == 8'd0)
          state_nx = S_REDIR;
      end
      S_REDIR: begin
        new_pc_valid = 1'b1;
        busy         = 1'b1;
        // CP0 has already committed EPC by now
        new_pc   = (kind_q == K_ERET) ? bus.epc
                                      : HANDLER_ADDR;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.excptype     = excptype;
  assign bus.excp_pc      = excp_pc;
  assign bus.flush        = flush;
  assign bus.new_pc       = new_pc;
  assign bus.new_pc_valid = new_pc_valid;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed bench for excp_ctrl: syscall, eret, masking,
// timer, priority/stall and mid-sequence reset.
module tb_excp_ctrl;

  logic clk;
  logic rst;
  int   chk;
  int   err;

  excp_ctrl_if bus ();

  excp_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.mem_valid  = 1'b0;
    bus.mem_pc     = 32'h0;
    bus.is_syscall = 1'b0;
    bus.is_eret    = 1'b0;
    bus.stall      = 1'b0;
    bus.intimer    = 1'b0;
    bus.status     = 32'h0;
    bus.cause      = 32'h0;
    bus.epc        = 32'h0;
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b1;
    cyc();
    cyc();
    chk++;
    if (bus.busy !== 1'b0 || bus.flush !== 1'b0 ||
        bus.new_pc_valid !== 1'b0 ||
        bus.excptype !== 32'h0 || bus.excp_pc !== 32'h0 ||
        bus.new_pc !== 32'h0) begin
      err++;
      $display("FAIL reset_outs busy=%b flush=%b nv=%b type=%h pc=%h npc=%h req all 0",
               bus.busy, bus.flush, bus.new_pc_valid,
               bus.excptype, bus.excp_pc, bus.new_pc);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_syscall();
    bus.status     = 32'h0000_0001;
    bus.mem_valid  = 1'b1;
    bus.is_syscall = 1'b1;
    bus.mem_pc     = 32'h100;
    cyc();
    bus.mem_valid  = 1'b0;
    bus.is_syscall = 1'b0;
    chk++;
    if (bus.excptype !== 32'h100 || bus.excp_pc !== 32'h100 ||
        bus.flush !== 1'b1 || bus.busy !== 1'b1) begin
      err++;
      $display("FAIL sys_issue type=%h pc=%h flush=%b busy=%b req 100/100/1/1",
               bus.excptype, bus.excp_pc, bus.flush, bus.busy);
    end
    cyc();
    chk++;
    if (bus.excptype !== 32'h0 || bus.flush !== 1'b1 ||
        bus.new_pc_valid !== 1'b0) begin
      err++;
      $display("FAIL sys_flush type=%h flush=%b nv=%b req 0/1/0",
               bus.excptype, bus.flush, bus.new_pc_valid);
    end
    cyc();
    chk++;
    if (bus.new_pc_valid !== 1'b1 || bus.new_pc !== 32'h40 ||
        bus.flush !== 1'b0) begin
      err++;
      $display("FAIL sys_redir nv=%b npc=%h flush=%b req 1/40/0",
               bus.new_pc_valid, bus.new_pc, bus.flush);
    end
    cyc();
    chk++;
    if (bus.busy !== 1'b0 || bus.new_pc_valid !== 1'b0 ||
        bus.new_pc !== 32'h0) begin
      err++;
      $display("FAIL sys_idle busy=%b nv=%b npc=%h req 0/0/0",
               bus.busy, bus.new_pc_valid, bus.new_pc);
    end
  endtask

  task automatic test_eret();
    bus.status    = 32'h0000_0003;
    bus.epc       = 32'h1234;
    bus.mem_valid = 1'b1;
    bus.is_eret   = 1'b1;
    bus.mem_pc    = 32'h300;
    cyc();
    bus.mem_valid = 1'b0;
    bus.is_eret   = 1'b0;
    chk++;
    if (bus.excptype !== 32'h200 || bus.excp_pc !== 32'h300) begin
      err++;
      $display("FAIL eret_issue type=%h pc=%h req 200/300",
               bus.excptype, bus.excp_pc);
    end
    cyc();
    chk++;
    if (bus.excptype !== 32'h0) begin
      err++;
      $display("FAIL eret_one_cycle type=%h req 0", bus.excptype);
    end
    cyc();
    chk++;
    if (bus.new_pc_valid !== 1'b1 || bus.new_pc !== 32'h1234) begin
      err++;
      $display("FAIL eret_redir nv=%b npc=%h req 1/1234",
               bus.new_pc_valid, bus.new_pc);
    end
    cyc();
    bus.status = 32'h0;
  endtask

  task automatic test_masking();
    bus.status = 32'h0000_0001;
    bus.cause  = 32'h0000_0400;
    bus.mem_pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk++;
      if (bus.busy !== 1'b0) begin
        err++;
        $display("FAIL mask_im0 cyc%0d busy=%b req 0", i, bus.busy);
      end
    end
    bus.status = 32'h0000_0401;
    cyc();
    bus.cause = 32'h0;
    chk++;
    if (bus.excptype !== 32'h4 || bus.excp_pc !== 32'h500) begin
      err++;
      $display("FAIL mask_int type=%h pc=%h req 4/500",
               bus.excptype, bus.excp_pc);
    end
    cyc(); cyc(); cyc();
    bus.status = 32'h0000_0403;
    bus.cause  = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk++;
      if (bus.busy !== 1'b0) begin
        err++;
        $display("FAIL mask_exl cyc%0d busy=%b req 0", i, bus.busy);
      end
    end
    bus.status = 32'h0000_0402;
    cyc();
    chk++;
    if (bus.busy !== 1'b0) begin
      err++;
      $display("FAIL mask_ie0 busy=%b req 0", bus.busy);
    end
    bus.cause  = 32'h0;
    bus.status = 32'h0;
    cyc();
  endtask

  task automatic test_timer();
    bus.status  = 32'h0000_0003;
    bus.mem_pc  = 32'h800;
    bus.intimer = 1'b1;
    cyc();
    bus.intimer = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk++;
      if (bus.busy !== 1'b0) begin
        err++;
        $display("FAIL timer_blocked cyc%0d busy=%b req 0", i, bus.busy);
      end
    end
    bus.status = 32'h0000_0001;
    cyc();
    chk++;
    if (bus.excptype !== 32'h4 || bus.excp_pc !== 32'h800) begin
      err++;
      $display("FAIL timer_issue type=%h pc=%h req 4/800",
               bus.excptype, bus.excp_pc);
    end
    cyc(); cyc(); cyc();
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk++;
      if (bus.busy !== 1'b0) begin
        err++;
        $display("FAIL timer_cleared cyc%0d busy=%b req 0", i, bus.busy);
      end
    end
    bus.status = 32'h0;
  endtask

  task automatic test_priority_stall();
    bus.status     = 32'h0000_0401;
    bus.cause      = 32'h0000_0400;
    bus.mem_valid  = 1'b1;
    bus.is_syscall = 1'b1;
    bus.mem_pc     = 32'h200;
    cyc();
    bus.cause = 32'h0;
    chk++;
    if (bus.excptype !== 32'h4) begin
      err++;
      $display("FAIL prio_int type=%h req 4", bus.excptype);
    end
    cyc(); cyc();
    chk++;
    if (bus.new_pc_valid !== 1'b1 || bus.new_pc !== 32'h40) begin
      err++;
      $display("FAIL prio_redir nv=%b npc=%h req 1/40",
               bus.new_pc_valid, bus.new_pc);
    end
    cyc();
    chk++;
    if (bus.busy !== 1'b0) begin
      err++;
      $display("FAIL prio_idle busy=%b req 0", bus.busy);
    end
    cyc();
    bus.mem_valid  = 1'b0;
    bus.is_syscall = 1'b0;
    chk++;
    if (bus.excptype !== 32'h100 || bus.excp_pc !== 32'h200) begin
      err++;
      $display("FAIL prio_resys type=%h pc=%h req 100/200",
               bus.excptype, bus.excp_pc);
    end
    cyc(); cyc(); cyc();
    bus.stall      = 1'b1;
    bus.mem_valid  = 1'b1;
    bus.is_syscall = 1'b1;
    bus.mem_pc     = 32'h240;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk++;
      if (bus.busy !== 1'b0) begin
        err++;
        $display("FAIL stall_hold cyc%0d busy=%b req 0", i, bus.busy);
      end
    end
    bus.stall = 1'b0;
    cyc();
    bus.stall      = 1'b1;
    bus.mem_valid  = 1'b0;
    bus.is_syscall = 1'b0;
    chk++;
    if (bus.excptype !== 32'h100 || bus.excp_pc !== 32'h240) begin
      err++;
      $display("FAIL stall_release type=%h pc=%h req 100/240",
               bus.excptype, bus.excp_pc);
    end
    cyc(); cyc();
    chk++;
    if (bus.new_pc_valid !== 1'b1) begin
      err++;
      $display("FAIL stall_ignored nv=%b req 1", bus.new_pc_valid);
    end
    cyc();
    clr();
  endtask

  task automatic test_reset_mid();
    bus.mem_valid  = 1'b1;
    bus.is_syscall = 1'b1;
    bus.mem_pc     = 32'h600;
    cyc();
    bus.mem_valid  = 1'b0;
    bus.is_syscall = 1'b0;
    cyc();
    chk++;
    if (bus.flush !== 1'b1) begin
      err++;
      $display("FAIL rmid_flush flush=%b req 1", bus.flush);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk++;
    if (bus.flush !== 1'b0 || bus.busy !== 1'b0 ||
        bus.new_pc_valid !== 1'b0) begin
      err++;
      $display("FAIL rmid_reset flush=%b busy=%b nv=%b req 0/0/0",
               bus.flush, bus.busy, bus.new_pc_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk++;
      if (bus.new_pc_valid !== 1'b0 || bus.busy !== 1'b0) begin
        err++;
        $display("FAIL rmid_quiet cyc%0d nv=%b busy=%b req 0/0",
                 i, bus.new_pc_valid, bus.busy);
      end
    end
    bus.mem_valid  = 1'b1;
    bus.is_syscall = 1'b1;
    bus.mem_pc     = 32'h700;
    cyc();
    bus.mem_valid  = 1'b0;
    bus.is_syscall = 1'b0;
    chk++;
    if (bus.excptype !== 32'h100 || bus.excp_pc !== 32'h700) begin
      err++;
      $display("FAIL rmid_again type=%h pc=%h req 100/700",
               bus.excptype, bus.excp_pc);
    end
    cyc(); cyc(); cyc();
  endtask

  initial begin
    chk = 0;
    err = 0;
    rst = 1'b1;
    clr();
    test_reset();
    test_syscall();
    test_eret();
    test_masking();
    test_timer();
    test_priority_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
